// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the word-serial sort controller.
package sort_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } sort_state_t;

  // Width needed to hold a count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/parallel_sorter.sv
// Combinational ascending sorter over N flattened lanes; lane 0 receives the minimum.
module parallel_sorter #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic [N*DW-1:0] in_flat,
  output logic [N*DW-1:0] out_flat
);

  logic [DW-1:0] lane_in [N];
  logic [DW-1:0] work    [N];
  logic [DW-1:0] tmp;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign lane_in[gi]              = in_flat[gi*DW +: DW];
      assign out_flat[gi*DW +: DW]    = work[gi];
    end
  endgenerate

  // Odd-even transposition network: N alternating passes fully sort N lanes.
  always_comb begin
    tmp = '0;
    for (int i = 0; i < N; i++) work[i] = lane_in[i];
    for (int p = 0; p < N; p++) begin
      for (int j = p % 2; j + 1 < N; j += 2) begin
        if (work[j] > work[j+1]) begin
          tmp       = work[j];
          work[j]   = work[j+1];
          work[j+1] = tmp;
        end
      end
    end
  end

endmodule

// File: rtl/sort_stream_ctrl.sv
// Collects up to N stream words, sorts them in one cycle and drains them ascending.
module sort_stream_ctrl
  import sort_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy
);

  localparam int CW = cnt_width(N);
  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  sort_state_t   state_q, state_d;
  logic          run_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] load_q   [N];
  logic [DW-1:0] load_d   [N];
  logic [DW-1:0] result_q [N];
  logic [DW-1:0] result_d [N];
  logic [N*DW-1:0] load_flat;
  logic [N*DW-1:0] sorted_flat;
  logic          last_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_flat
      assign load_flat[gi*DW +: DW] = load_q[gi];
    end
  endgenerate

  parallel_sorter #(.N(N), .DW(DW)) u_sorter (
    .in_flat  (load_flat),
    .out_flat (sorted_flat)
  );

  // Outputs decode registered state only; run_q keeps in_ready low until the first edge after reset.
  always_comb begin
    last_hit  = (CW'(idx_q) == len_q - CW'(1));
    in_ready  = (state_q == FILL) && run_q;
    out_valid = (state_q == DRAIN);
    out_last  = out_valid && last_hit;
    busy      = (state_q != FILL);
    out_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (out_valid && IW'(i) == idx_q) out_data = result_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    idx_d    = idx_q;
    load_d   = load_q;
    result_d = result_q;
    case (state_q)
      FILL: begin
        if (in_valid && in_ready) begin
          for (int i = 0; i < N; i++) begin
            if (CW'(i) == cnt_q) load_d[i] = in_data;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == N_CNT || in_last) begin
            state_d = SORT;
            // Padding with the maximum value keeps real words in the low lanes.
            for (int i = 0; i < N; i++) begin
              if (CW'(i) >= cnt_d) load_d[i] = '1;
            end
          end
        end
      end
      SORT: begin
        for (int i = 0; i < N; i++) result_d[i] = sorted_flat[i*DW +: DW];
        len_d   = cnt_q;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (out_ready) begin
          if (last_hit) begin
            state_d = FILL;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      run_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      for (int i = 0; i < N; i++) begin
        load_q[i]   <= '0;
        result_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      load_q   <= load_d;
      result_q <= result_d;
    end
  end

endmodule
